// File: rtl/palette_fade_ctrl_if.sv
// Command, ROM-read and palette-write bundle for palette_fade_ctrl.
// master = the fade controller, slave = game FSM / ROM / palette RAM side.
interface palette_fade_ctrl_if #(
  parameter int IDX_W = 4,
  parameter int CH_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [4:0]        cmd_level;
  logic [IDX_W-1:0]  base_index;
  logic [3*CH_W-1:0] base_rgb;
  logic              pal_we;
  logic [IDX_W-1:0]  pal_waddr;
  logic [3*CH_W-1:0] pal_wdata;
  logic [4:0]        level;
  logic              busy;
  logic              done;

  modport master (
    input  cmd_valid, cmd_op, cmd_level, base_rgb,
    output cmd_ready, base_index, pal_we, pal_waddr, pal_wdata, level, busy, done
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_level, base_rgb,
    input  cmd_ready, base_index, pal_we, pal_waddr, pal_wdata, level, busy, done
  );
endinterface

// File: rtl/palette_fade_ctrl.sv
// Frame-synced palette fader: on vblank, sweeps all entries ROM -> scale -> palette RAM.
// One-stage pipeline from base_index to the write port; commands accepted only while idle.
module palette_fade_ctrl #(
  parameter int NUM_ENTRIES     = 16,
  parameter int IDX_W           = 4,
  parameter int CH_W            = 4,
  parameter int KEY_INDEX       = 0,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic vblank,
  palette_fade_ctrl_if.master bus
);
  localparam int FC_W = (FRAMES_PER_STEP < 2) ? 1 : $clog2(FRAMES_PER_STEP + 1);

  localparam logic [1:0] OP_SET      = 2'b00;
  localparam logic [1:0] OP_FADE_OUT = 2'b01;
  localparam logic [1:0] OP_FADE_IN  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN} state_e;
  typedef enum logic [1:0] {M_HOLD, M_DOWN, M_UP} mode_e;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [4:0]        level_q, level_d;
  logic              pending_q, pending_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic              we_q, we_d;
  logic [IDX_W-1:0]  waddr_q, waddr_d;
  logic [3*CH_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic [3*CH_W-1:0] scaled;

  always_comb begin
    scaled = '0;
    for (int ch = 0; ch < 3; ch++) begin
      logic [CH_W+4:0] prod;
      prod = (CH_W+5)'(bus.base_rgb[ch*CH_W +: CH_W]) * (CH_W+5)'(level_q);
      scaled[ch*CH_W +: CH_W] = CH_W'(prod >> 4);
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    level_d   = level_q;
    pending_d = pending_q;
    fcnt_d    = fcnt_q;
    addr_d    = addr_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    we_d      = (state_q == S_SWEEP);
    done_d    = 1'b0;

    if (state_q == S_SWEEP) begin
      waddr_d = addr_q;
      wdata_d = (addr_q == IDX_W'(KEY_INDEX)) ? bus.base_rgb : scaled;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          unique case (bus.cmd_op)
            OP_SET: begin
              level_d   = (bus.cmd_level > 5'd16) ? 5'd16 : bus.cmd_level;
              mode_d    = M_HOLD;
              pending_d = 1'b1;
            end
            OP_FADE_OUT: begin
              mode_d = M_DOWN;
              fcnt_d = '0;
            end
            OP_FADE_IN: begin
              mode_d = M_UP;
              fcnt_d = '0;
            end
            default: mode_d = M_HOLD;
          endcase
        end
        // vblank sees the mode/level the command just produced
        if (vblank) begin
          if (mode_d != M_HOLD) begin
            if (fcnt_d == FC_W'(FRAMES_PER_STEP - 1)) begin
              fcnt_d    = '0;
              pending_d = 1'b1;
              if (mode_d == M_DOWN) begin
                if (level_d != 5'd0) level_d = level_d - 5'd1;
              end else begin
                if (level_d != 5'd16) level_d = level_d + 5'd1;
              end
            end else begin
              fcnt_d = fcnt_d + 1'b1;
            end
          end
          if (pending_d) begin
            pending_d = 1'b0;
            addr_d    = '0;
            state_d   = S_SWEEP;
          end
        end
      end
      S_SWEEP: begin
        if (addr_q == IDX_W'(NUM_ENTRIES - 1)) begin
          addr_d  = '0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        if ((mode_q == M_DOWN && level_q == 5'd0) || (mode_q == M_UP && level_q == 5'd16)) begin
          done_d = 1'b1;
          mode_d = M_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      mode_q    <= M_HOLD;
      level_q   <= 5'd16;
      pending_q <= 1'b1;
      fcnt_q    <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      level_q   <= level_d;
      pending_q <= pending_d;
      fcnt_q    <= fcnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
    end
  end

  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q == S_SWEEP);
  assign bus.base_index = addr_q;
  assign bus.pal_we     = we_q;
  assign bus.pal_waddr  = waddr_q;
  assign bus.pal_wdata  = wdata_q;
  assign bus.level      = level_q;
  assign bus.done       = done_q;
endmodule
